// File: rtl/trig_stamp_ctrl_pkg.sv
// Shared constants and the clear-sequencer state encoding for the trigger stamp controller.
package trig_stamp_ctrl_pkg;

  localparam int unsigned BC_WIDTH        = 8;
  localparam int unsigned L1ID_WIDTH_DEF  = 5;

  // Clear sequencer: RUN waits for a command, CLEAR drives the strobe, SETTLE blanks re-triggering.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2
  } clr_state_e;

  // One FIFO entry holds {BC stamp, L1 ID, BC error}.
  function automatic int unsigned entry_width(input int unsigned l1id_w);
    return BC_WIDTH + l1id_w + 1;
  endfunction

  localparam int unsigned ENTRY_WIDTH_DEF = BC_WIDTH + L1ID_WIDTH_DEF + 1;

endpackage

// File: rtl/trig_stamp_ctrl_stamp_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally from registered storage.
module stamp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 14
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             head_c,
  output logic                         push_acc_c,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_acc_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_acc_c  = pop & ~flush & (count_q != '0);
    push_acc_c = push & ~flush & ((count_q != CNT_W'(DEPTH)) | pop_acc_c);
  end

  // Pointers and occupancy; flush empties the FIFO and rewinds both pointers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_acc_c);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_acc_c);
      count_q  <= count_q + CNT_W'(push_acc_c) - CNT_W'(pop_acc_c);
    end
  end

  // Storage carries no reset; an empty FIFO never exposes it.
  always_ff @(posedge Clk) begin
    if (push_acc_c) mem[wr_ptr_q] <= wdata;
  end

  assign head_c = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign count  = count_q;

endmodule

// File: rtl/trig_stamp_ctrl.sv
// L1 trigger time-stamper: stamps BC/L1ID into a FIFO and sequences bunch-counter clears.
module trig_stamp_ctrl
  import trig_stamp_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned L1ID_WIDTH = L1ID_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Trigger,
  input  logic                  BCR,
  input  logic                  ECR,
  input  logic [BC_WIDTH-1:0]   BC,
  input  logic                  BCError,
  output logic                  ClearBC,
  output logic                  TrigValid,
  input  logic                  TrigAck,
  output logic [BC_WIDTH-1:0]   TrigBC,
  output logic [L1ID_WIDTH-1:0] TrigL1ID,
  output logic                  TrigErr,
  output logic                  Overflow,
  output logic                  ErrorFlag
);

  localparam int unsigned ENTRY_W = entry_width(L1ID_WIDTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [BC_WIDTH-1:0]   bc;
    logic [L1ID_WIDTH-1:0] l1id;
    logic                  err;
  } stamp_t;

  clr_state_e            state_q;
  clr_state_e            state_d;
  logic                  clear_bc_q;
  logic [L1ID_WIDTH-1:0] l1id_q;
  logic                  overflow_q;
  logic                  error_q;
  logic                  push_c;
  logic                  pop_c;
  logic                  push_acc_c;
  logic [CNT_W-1:0]      occ;
  stamp_t                wr_entry_c;
  stamp_t                head_c;
  logic [ENTRY_W-1:0]    head_raw_c;

  // ECR discards any coincident trigger or acknowledge.
  always_comb begin
    push_c     = Trigger & ~ECR;
    pop_c      = TrigAck & ~ECR;
    wr_entry_c = '{bc: BC, l1id: l1id_q, err: BCError};
    head_c     = stamp_t'(head_raw_c);
  end

  stamp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .push       (push_c),
    .pop        (pop_c),
    .flush      (ECR),
    .wdata      (ENTRY_W'(wr_entry_c)),
    .head_c     (head_raw_c),
    .push_acc_c (push_acc_c),
    .count      (occ)
  );

  // Clear sequencer state register; ClearBC is registered from the next state.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_RUN;
      clear_bc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clear_bc_q <= (state_d == ST_CLEAR);
    end
  end

  // Commands only start a clear from RUN; CLEAR and SETTLE always run to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (BCR || ECR) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // L1ID counts every trigger, accepted or dropped; ECR rewinds it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       l1id_q <= '0;
    else if (ECR)     l1id_q <= '0;
    else if (Trigger) l1id_q <= l1id_q + L1ID_WIDTH'(1);
  end

  // Sticky status flags; ECR clears them with priority over a new set.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else if (ECR) begin
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (push_c && !push_acc_c) overflow_q <= 1'b1;
      if (BCError)               error_q    <= 1'b1;
    end
  end

  assign ClearBC   = clear_bc_q;
  assign TrigValid = (occ != '0);
  assign TrigBC    = head_c.bc;
  assign TrigL1ID  = head_c.l1id;
  assign TrigErr   = head_c.err;
  assign Overflow  = overflow_q;
  assign ErrorFlag = error_q;

endmodule

// File: tb/tb_trig_stamp_ctrl.sv
// Scoreboard bench for trig_stamp_ctrl: expected stamps are queued when triggers are driven.
module tb_trig_stamp_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned L1W   = 5;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic           Trigger = 1'b0, BCR = 1'b0, ECR = 1'b0, BCError = 1'b0, TrigAck = 1'b0;
  logic [7:0]     BC = 8'h00;
  logic           ClearBC, TrigValid, TrigErr, Overflow, ErrorFlag;
  logic [7:0]     TrigBC;
  logic [L1W-1:0] TrigL1ID;

  typedef struct {
    logic [7:0]     bc;
    logic [L1W-1:0] l1id;
    logic           err;
  } exp_t;

  exp_t           exp_q[$];
  logic [L1W-1:0] m_l1id = '0;
  logic           m_ovf = 1'b0;
  logic           m_err = 1'b0;
  int             checks = 0;
  int             errors = 0;

  trig_stamp_ctrl #(.FIFO_DEPTH(DEPTH), .L1ID_WIDTH(L1W)) dut (
    .Clk(Clk), .Reset(Reset), .Trigger(Trigger), .BCR(BCR), .ECR(ECR), .BC(BC),
    .BCError(BCError), .ClearBC(ClearBC), .TrigValid(TrigValid), .TrigAck(TrigAck),
    .TrigBC(TrigBC), .TrigL1ID(TrigL1ID), .TrigErr(TrigErr), .Overflow(Overflow),
    .ErrorFlag(ErrorFlag)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, advance the reference model, step past the posedge.
  task automatic tick(input logic trig, input logic bcr, input logic ecr,
                      input logic [7:0] bc, input logic bcerr, input logic ack);
    exp_t e;
    bit   pop_ok;
    Trigger = trig; BCR = bcr; ECR = ecr; BC = bc; BCError = bcerr; TrigAck = ack;
    if (ecr) begin
      exp_q.delete(); m_l1id = '0; m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      pop_ok = ack && (exp_q.size() != 0);
      if (trig) begin
        if (exp_q.size() < DEPTH || pop_ok) begin
          e.bc = bc; e.l1id = m_l1id; e.err = bcerr;
          if (pop_ok) void'(exp_q.pop_front());
          exp_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (pop_ok) void'(exp_q.pop_front());
        end
        m_l1id = m_l1id + 1'b1;
      end else if (pop_ok) begin
        void'(exp_q.pop_front());
      end
      if (bcerr) m_err = 1'b1;
    end
    @(posedge Clk); #1;
    Trigger = 1'b0; BCR = 1'b0; ECR = 1'b0; BCError = 1'b0; TrigAck = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (TrigValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", TrigValid); end
    checks++; if (ClearBC !== 1'b0) begin errors++; $display("FAIL rst_clearbc got %b want 0", ClearBC); end
    checks++; if ({TrigBC, TrigL1ID, TrigErr} !== '0) begin errors++; $display("FAIL rst_head got %h/%h/%b want 0", TrigBC, TrigL1ID, TrigErr); end
    checks++; if ({Overflow, ErrorFlag} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b%b want 00", Overflow, ErrorFlag); end
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b1;
    tick(0, 0, 0, 8'h01, 0, 0);
    checks++; if ({TrigValid, ClearBC} !== 2'b00) begin errors++; $display("FAIL rst_release got %b%b want 00", TrigValid, ClearBC); end
  endtask

  task automatic test_clear_fsm();
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 8'(i), 0, 0);
    tick(1, 1, 0, 8'h77, 0, 0);
    checks++; if (ClearBC !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b want 1", ClearBC); end
    checks++; if (TrigBC !== 8'h77) begin errors++; $display("FAIL clr_preclear_bc got %h want 77", TrigBC); end
    tick(1, 1, 0, 8'h78, 0, 0);
    checks++; if (ClearBC !== 1'b0) begin errors++; $display("FAIL clr_single got %b want 0", ClearBC); end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 8'h79, 0, 0);
      checks++; if (ClearBC !== 1'b0) begin errors++; $display("FAIL clr_no_repeat[%0d] got %b want 0", i, ClearBC); end
    end
    while (exp_q.size() != 0) begin
      checks++;
      if ({TrigValid, TrigBC, TrigL1ID, TrigErr} !== {1'b1, exp_q[0].bc, exp_q[0].l1id, exp_q[0].err}) begin
        errors++; $display("FAIL clr_drain got %b/%h/%h/%b want 1/%h/%h/%b", TrigValid, TrigBC, TrigL1ID, TrigErr, exp_q[0].bc, exp_q[0].l1id, exp_q[0].err);
      end
      tick(0, 0, 0, 8'h79, 0, 1);
    end
    checks++; if (TrigValid !== 1'b0) begin errors++; $display("FAIL clr_empty got %b want 0", TrigValid); end
  endtask

  task automatic test_stamp();
    tick(0, 0, 1, 8'h20, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h21, 0, 0);
    tick(1, 0, 0, 8'h2A, 0, 0);
    checks++; if ({TrigValid, TrigBC, TrigL1ID} !== {1'b1, 8'h2A, 5'd0}) begin errors++; $display("FAIL stamp_first got %b/%h/%h want 1/2a/00", TrigValid, TrigBC, TrigL1ID); end
    tick(0, 0, 0, 8'h2B, 0, 0);
    tick(0, 0, 0, 8'h2C, 0, 0);
    tick(1, 0, 0, 8'h2D, 0, 0);
    checks++; if ({TrigBC, TrigL1ID} !== {exp_q[0].bc, exp_q[0].l1id}) begin errors++; $display("FAIL stamp_head got %h/%h want %h/%h", TrigBC, TrigL1ID, exp_q[0].bc, exp_q[0].l1id); end
    tick(0, 0, 0, 8'h2E, 0, 1);
    checks++; if ({TrigValid, TrigBC, TrigL1ID} !== {1'b1, 8'h2D, 5'd1}) begin errors++; $display("FAIL stamp_second got %b/%h/%h want 1/2d/01", TrigValid, TrigBC, TrigL1ID); end
    tick(0, 0, 0, 8'h2F, 0, 1);
    checks++; if (TrigValid !== 1'b0) begin errors++; $display("FAIL stamp_empty got %b want 0", TrigValid); end
  endtask

  task automatic test_full_push();
    int n;
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 0, 8'(8'h10 + i), 0, 0);
    checks++; if ({TrigBC, Overflow} !== {8'h10, 1'b0}) begin errors++; $display("FAIL full_head got %h/%b want 10/0", TrigBC, Overflow); end
    tick(1, 0, 0, 8'h90, 0, 1);
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL full_push_ovf got %b want 0", Overflow); end
    n = 0;
    while (TrigValid === 1'b1 && n < 20) begin
      checks++;
      if (exp_q.size() == 0 || {TrigBC, TrigL1ID} !== {exp_q[0].bc, exp_q[0].l1id}) begin
        errors++; $display("FAIL full_drain[%0d] got %h/%h queue %0d", n, TrigBC, TrigL1ID, exp_q.size());
      end
      n++;
      tick(0, 0, 0, 8'h91, 0, 1);
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL full_occupancy got %0d want %0d", n, DEPTH); end
  endtask

  task automatic test_overflow();
    int n;
    logic [L1W-1:0] last;
    tick(0, 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 9; i++) tick(1, 0, 0, 8'(8'h40 + i), 0, 0);
    checks++; if ({Overflow, TrigL1ID} !== {1'b1, 5'd0}) begin errors++; $display("FAIL ovf_set got %b/%h want 1/00", Overflow, TrigL1ID); end
    tick(0, 0, 0, 8'h50, 0, 1);
    tick(1, 0, 0, 8'hA0, 0, 0);
    n = 0; last = '0;
    while (TrigValid === 1'b1 && n < 20) begin
      checks++;
      if (exp_q.size() == 0 || {TrigBC, TrigL1ID} !== {exp_q[0].bc, exp_q[0].l1id}) begin
        errors++; $display("FAIL ovf_drain[%0d] got %h/%h queue %0d", n, TrigBC, TrigL1ID, exp_q.size());
      end
      last = TrigL1ID; n++;
      tick(0, 0, 0, 8'h51, 0, 1);
    end
    checks++; if ({n, last} !== {32'(DEPTH), 5'd9}) begin errors++; $display("FAIL ovf_entries got %0d last %h want %0d last 09", n, last, DEPTH); end
    checks++; if (Overflow !== m_ovf) begin errors++; $display("FAIL ovf_sticky got %b want %b", Overflow, m_ovf); end
  endtask

  task automatic test_wrap();
    tick(0, 0, 1, 8'h00, 0, 0);
    checks++; if ({Overflow, TrigValid} !== 2'b00) begin errors++; $display("FAIL wrap_ecr got %b%b want 00", Overflow, TrigValid); end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 33; i++) begin
      if (exp_q.size() != 0) begin
        checks++;
        if ({TrigBC, TrigL1ID} !== {exp_q[0].bc, exp_q[0].l1id}) begin
          errors++; $display("FAIL wrap_head[%0d] got %h/%h want %h/%h", i, TrigBC, TrigL1ID, exp_q[0].bc, exp_q[0].l1id);
        end
      end
      tick(1, 0, 0, 8'(i), 0, 1);
    end
    checks++; if ({TrigValid, TrigBC, TrigL1ID} !== {1'b1, 8'd32, 5'd0}) begin errors++; $display("FAIL wrap_33rd got %b/%h/%h want 1/20/00", TrigValid, TrigBC, TrigL1ID); end
    tick(0, 0, 0, 8'h00, 0, 1);
  endtask

  task automatic test_ecr_err();
    tick(1, 0, 0, 8'h55, 1, 0);
    checks++; if ({TrigErr, ErrorFlag, TrigBC} !== {1'b1, 1'b1, 8'h55}) begin errors++; $display("FAIL err_capture got %b/%b/%h want 1/1/55", TrigErr, ErrorFlag, TrigBC); end
    tick(1, 0, 1, 8'h56, 0, 1);
    checks++; if ({TrigValid, ErrorFlag, ClearBC} !== 3'b001) begin errors++; $display("FAIL ecr_flush got %b%b%b want 001", TrigValid, ErrorFlag, ClearBC); end
    tick(0, 0, 0, 8'h57, 0, 0);
    checks++; if (ClearBC !== 1'b0) begin errors++; $display("FAIL ecr_pulse_len got %b want 0", ClearBC); end
    tick(1, 0, 0, 8'h66, 0, 0);
    checks++; if ({TrigL1ID, TrigErr, TrigBC} !== {5'd0, 1'b0, 8'h66}) begin errors++; $display("FAIL ecr_l1id got %h/%b/%h want 00/0/66", TrigL1ID, TrigErr, TrigBC); end
    tick(0, 0, 1, 8'h67, 1, 0);
    checks++; if (ErrorFlag !== 1'b0) begin errors++; $display("FAIL ecr_wins got %b want 0", ErrorFlag); end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 8'h68, 0, 0);
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 8'(8'hC0 + i), 0, 0);
    tick(0, 1, 0, 8'hC3, 0, 0);
    checks++; if ({ClearBC, TrigValid} !== 2'b11) begin errors++; $display("FAIL mid_pre got %b%b want 11", ClearBC, TrigValid); end
    Reset = 1'b0;
    #2;
    checks++; if ({ClearBC, TrigValid, TrigBC} !== 10'b0) begin errors++; $display("FAIL mid_async got %b/%b/%h want 0/0/00", ClearBC, TrigValid, TrigBC); end
    @(posedge Clk); #1;
    Reset = 1'b1;
    exp_q.delete(); m_l1id = '0; m_ovf = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 8'hD0, 0, 0);
      checks++; if ({ClearBC, TrigValid} !== 2'b00) begin errors++; $display("FAIL mid_no_pulse[%0d] got %b%b want 00", i, ClearBC, TrigValid); end
    end
    tick(1, 0, 0, 8'hD1, 0, 0);
    checks++; if ({TrigValid, TrigL1ID} !== {1'b1, 5'd0}) begin errors++; $display("FAIL mid_l1id got %b/%h want 1/00", TrigValid, TrigL1ID); end
  endtask

  initial begin
    test_reset();
    test_clear_fsm();
    test_stamp();
    test_full_push();
    test_overflow();
    test_wrap();
    test_ecr_err();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_stamp_ctrl.md
TRIG_STAMP_CTRL -- requirements
Module: trig_stamp_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, trigger-stamp FIFO entries; power of two, 2..32.
REQ-002 Parameter L1ID_WIDTH, default 5, width of the L1 trigger ID counter.
REQ-003 Reset is asynchronous and active-low; the clock is Clk.
REQ-004 Clk  input  1  system clock; all state updates on posedge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Trigger  input  1  L1 trigger, one pulse per trigger, sampled on posedge.
REQ-007 BCR  input  1  bunch-counter-reset command, single-cycle pulse.
REQ-008 ECR  input  1  event-counter-reset command, single-cycle pulse.
REQ-009 BC  input  8  voted bunch-counter value (counter updates on negedge, stable at posedge).
REQ-010 BCError  input  1  voted TMR mismatch flag from the bunch counter.
REQ-011 ClearBC  output  1  clear strobe to the bunch counter.
REQ-012 TrigValid  output  1  FIFO head entry valid.
REQ-013 TrigAck  input  1  consumer pops the head entry when TrigValid=1.
REQ-014 TrigBC  output  8  BC stamp of the head entry.
REQ-015 TrigL1ID  output  L1ID_WIDTH  L1 ID of the head entry.
REQ-016 TrigErr  output  1  BCError state captured with the head entry.
REQ-017 Overflow  output  1  sticky flag: a trigger was dropped.
REQ-018 ErrorFlag  output  1  sticky flag: BCError was seen.

Function
REQ-019 Clear FSM has states RUN, CLEAR and SETTLE; RUN->CLEAR on BCR or ECR; CLEAR->SETTLE unconditionally; SETTLE->RUN unconditionally; ClearBC=1 only in CLEAR, so exactly one cycle, starting one cycle after the command.
REQ-020 BCR or ECR arriving in CLEAR or SETTLE is ignored by the FSM; no second pulse is generated.
REQ-021 Trigger in any FSM state stamps the BC value present at that posedge, including the cycle BCR is asserted (pre-clear value).
REQ-022 Accepted trigger pushes {BC, L1ID counter, BCError} and increments the L1ID counter modulo 2^L1ID_WIDTH (wrap max->0).
REQ-023 Push is accepted if occupancy < FIFO_DEPTH, or if occupancy = FIFO_DEPTH and a pop occurs the same cycle.
REQ-024 Trigger refused for lack of space: no push, L1ID still increments, Overflow set.
REQ-025 ECR, in the same cycle: flushes the FIFO (occupancy 0), sets L1ID to 0, clears Overflow and ErrorFlag; a coincident Trigger and TrigAck are discarded.
REQ-026 TrigValid = (occupancy != 0); TrigBC/TrigL1ID/TrigErr show the head entry combinationally from registered storage; TrigAck with TrigValid=0 is ignored.
REQ-027 Push-to-TrigValid latency is 1 cycle (first-word visible the cycle after the trigger posedge).
REQ-028 ErrorFlag sets on any posedge with BCError=1; set has priority over nothing except ECR (ECR wins).
REQ-029 Occupancy counter width is log2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 Reset low forces: FSM=RUN, ClearBC=0, occupancy=0, pointers=0, L1ID=0, TrigValid=0, Overflow=0, ErrorFlag=0; TrigBC/TrigL1ID/TrigErr=0.
REQ-031 Reset mid-operation discards the FIFO contents and any pending clear; no ClearBC pulse follows reset release.
REQ-032 FIFO storage array needs no reset; outputs are gated to 0 when occupancy is 0.

Structure
REQ-033 Shared package holds FSM state encoding (RUN, CLEAR, SETTLE), the FIFO entry width constant (8+L1ID_WIDTH+1) and the BC width constant 8.
REQ-034 One sub-module, stamp_fifo (synchronous FIFO with push/pop/flush, occupancy out); the FSM and L1ID counter stay in trig_stamp_ctrl.

Verification
REQ-035 BCR pulse at cycle 10 -> ClearBC=1 at cycle 11 only; BCR again at 11 -> no extra pulse.
REQ-036 Trigger at BC=0x2A, then again 3 cycles later -> entries (0x2A, L1ID 0) and (0x2D, L1ID 1), TrigValid the cycle after the first trigger.
REQ-037 9 triggers with FIFO_DEPTH=8 and no TrigAck -> 8 entries, Overflow=1, 9th dropped, next accepted trigger carries L1ID 9.
REQ-038 FIFO full, Trigger and TrigAck in the same cycle -> push accepted, occupancy stays 8, Overflow stays 0.
REQ-039 32 triggers with L1ID_WIDTH=5 and continuous acks -> L1IDs 0..31, 33rd trigger carries L1ID 0.
REQ-040 BCError=1 for one cycle with Trigger, then ECR with Trigger -> first entry TrigErr=1, ErrorFlag=1; after ECR occupancy=0, ErrorFlag=0, L1ID=0, ClearBC pulses one cycle later.
